dct_1d_gen: RTL and testbench
=============================

Name: dct_1d_gen

Overview:
- Parametrised 8-point 1-D DCT/IDCT row engine; successor to the fixed 8-bit/12-bit forward-only dct_1d.
- Consumes one signed sample per accepted cycle and emits 8 signed coefficients per row in index order.
- Mode (forward/inverse) is selectable per row.
- Sits between the pixel/coefficient stream and the transpose buffer of the 2-D DCT; uses the same ena/rdy streaming handshake.

Parameters:
- IN_W, 8, input sample width (signed).
- OUT_W, 12, output coefficient width (signed).
- COEF_W, 12, basis coefficient width: signed, COEF_W-1 fractional bits.
- ACC_W, IN_W+COEF_W+3, accumulator width.

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- ena_in  in  1  upstream sample valid
- rdy_out  out  1  block can accept a sample this cycle
- a_in  in  IN_W  input sample: x[n] in forward mode, S[k] in inverse mode
- inv_in  in  1  mode for the row; sampled only with the row's first sample (1 = inverse)
- ena_out  out  1  S_out valid
- rdy_in  in  1  downstream ready
- S_out  out  OUT_W  output coefficient/sample
- inv_out  out  1  mode of the row currently on S_out

Behaviour:
- Basis: C[k][n] = c(k)/2 * cos((2n+1)k*pi/16), with c(0) = 1/sqrt(2) and c(k>0) = 1.
  - Stored as an 8x8 constant ROM in COEF_W bits, round-to-nearest.
- Forward mode: out[k] = sum_n C[k][n]*x[n]. Inverse mode: out[n] = sum_k C[k][n]*S[k].
- Datapath: 8 parallel multiply-accumulators.
  - On accept of input index i (0..7), acc[j] += a_in*Cm[j][i] for all j.
  - Cm = C in forward mode; Cm = transpose of C in inverse mode.
- Input accept: posedge with ena_in && rdy_out. Input counter cnt 0..7.
  - Gaps (ena_in low) are allowed anywhere; no timeout.
- Row mode is latched from inv_in when cnt=0. Changes to inv_in mid-row are ignored.
- Accumulator state machine:
  - FILL: cnt counts accepted samples. After the 8th accept, go to FULL.
  - FULL: row complete, held until the output bank is free.
    - Bank is free when bank_valid=0, or when its last word (idx 7) is being taken this cycle.
    - On transfer: bank <= round/clip(acc[0..7]), bank_valid <= 1, idx <= 0, inv_out <= latched mode, state returns to FILL.
- rdy_out = (state==FILL) || transfer_this_cycle.
  - A sample accepted in the transfer cycle starts the next row: acc <= product, not acc+product.
  - Result: full throughput, 8 samples per 8 cycles, when downstream never stalls.
- Output: ena_out = bank_valid, S_out = bank[idx].
  - On ena_out && rdy_in: idx++. After idx 7 is taken, bank_valid <= 0 unless reloaded the same cycle.
  - S_out and ena_out hold stable while rdy_in is low.
- Latency: first output of a row is valid the cycle after the row's 8th sample is accepted, provided the bank is free.
- Scaling: result = (acc + 2^(COEF_W-2)) >>> (COEF_W-1), i.e. round half up, then reduced to OUT_W (see Optional Feature).
- Reset (async, any time, including mid-row or mid-output):
  - cnt=0, state=FILL, all acc=0, bank_valid=0, idx=0.
  - ena_out=0, S_out=0, inv_out=0, rdy_out=1.
  - A partial row is discarded.

Optional Feature:
- Macro DCT_SAT_EN.
- Defined: the rounded result is saturated to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
- Undefined: the rounded result is truncated to its low OUT_W bits (two's-complement wrap).
- Ports and timing are identical in both builds.

Test Plan:
- DC row, forward: 8 samples of 100, inv_in=0, rdy_in=1 -> S_out = 283, then 0 x7 (tolerance +/-1); ena_out rises 1 cycle after the 8th accept.
- Inverse impulse: S = {64,0,0,0,0,0,0,0}, inv_in=1 -> eight outputs of 23 (+/-1); inv_out=1 during all eight.
- Round trip: row {65,84,88,74,71,84,91,86} forward, then its outputs fed back in inverse mode -> original values recovered within +/-2.
- Backpressure and throughput:
  - Stream 3 rows back to back with rdy_in=1 -> 24 outputs on consecutive cycles, rdy_out never low.
  - Repeat with rdy_in low for 20 cycles after the first output -> rdy_out drops after row 2 completes; all 24 outputs arrive in order, none lost or duplicated.
- Saturation, OUT_W=9: row of 8 x 127, forward -> S[0] = 255 with DCT_SAT_EN defined; -153 (i.e. 359-512) without it.
- Reset mid-row: assert rst after 4 accepted samples -> ena_out=0 and rdy_out=1 immediately; the following DC row of 100 yields 283 and seven zeros.

Source files
------------

// File: rtl/dct_1d_gen.sv
// 8-point 1-D DCT/IDCT row engine with ena/rdy streaming and per-row mode select.
// Build option DCT_SAT_EN: saturate rounded results to OUT_W instead of two's-complement wrap.
module dct_1d_gen #(
   parameter int unsigned IN_W   = 8,
   parameter int unsigned OUT_W  = 12,
   parameter int unsigned COEF_W = 12,
   parameter int unsigned ACC_W  = IN_W + COEF_W + 3
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    ena_in,
   output logic                    rdy_out,
   input  logic signed [IN_W-1:0]  a_in,
   input  logic                    inv_in,
   output logic                    ena_out,
   input  logic                    rdy_in,
   output logic signed [OUT_W-1:0] S_out,
   output logic                    inv_out
);

   localparam int unsigned PROD_W = IN_W + COEF_W;
   // Basis magnitudes are tabulated with 24 fractional bits, then rounded to COEF_W-1 (COEF_W <= 24).
   localparam int unsigned REF_SH = 25 - COEF_W;
   localparam logic signed [ACC_W-1:0] RND_HALF = ACC_W'(1 << (COEF_W - 2));
`ifdef DCT_SAT_EN
   localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'((1 << (OUT_W - 1)) - 1);
   localparam logic signed [ACC_W-1:0] SAT_LO = -SAT_HI - ACC_W'(1);
`endif

   typedef enum logic {FILL, FULL} state_t;

   // C[k][n] = c(k)/2 * cos((2n+1)k*pi/16), folded onto the first quadrant for the magnitude.
   function automatic logic signed [COEF_W-1:0] coef_val(input int k, input int n);
      int     m;
      int     mi;
      logic   neg;
      longint mag;
      m   = ((2 * n + 1) * k) % 32;
      neg = (m > 8) && (m < 24);
      if (m <= 8)       mi = m;
      else if (m <= 16) mi = 16 - m;
      else if (m <= 24) mi = m - 16;
      else              mi = 32 - m;
      case (mi)
         0:       mag = 64'd5931642;
         1:       mag = 64'd8227423;
         2:       mag = 64'd7750063;
         3:       mag = 64'd6974873;
         4:       mag = 64'd5931642;
         5:       mag = 64'd4660461;
         6:       mag = 64'd3210182;
         7:       mag = 64'd1636536;
         default: mag = 64'd0;
      endcase
      mag = (mag + (64'd1 << (REF_SH - 1))) >> REF_SH;
      return neg ? COEF_W'(-mag) : COEF_W'(mag);
   endfunction

   logic signed [COEF_W-1:0] rom [8][8];

   for (genvar k = 0; k < 8; k++) begin : g_row
      for (genvar n = 0; n < 8; n++) begin : g_col
         assign rom[k][n] = coef_val(k, n);
      end
   end

   state_t                   state;
   logic [2:0]               cnt;
   logic [2:0]               idx;
   logic                     mode_q;
   logic                     bank_valid;
   logic signed [ACC_W-1:0]  acc     [8];
   logic signed [OUT_W-1:0]  bank    [8];
   logic signed [COEF_W-1:0] cm      [8];
   logic signed [PROD_W-1:0] prod    [8];
   logic signed [ACC_W-1:0]  acc_nxt [8];
   logic signed [OUT_W-1:0]  res     [8];
`ifdef DCT_SAT_EN
   logic signed [ACC_W-1:0]  rnd     [8];
`endif
   logic                     take;
   logic                     bank_free;
   logic                     transfer;
   logic                     accept;
   logic                     row_inv;

   // Handshake: a finished row moves into the bank when the bank is empty or draining its last word.
   always_comb begin
      take      = bank_valid && rdy_in;
      bank_free = !bank_valid || (take && (idx == 3'd7));
      transfer  = (state == FULL) && bank_free;
      rdy_out   = (state == FILL) || transfer;
      accept    = ena_in && rdy_out;
      row_inv   = (cnt == 3'd0) ? inv_in : mode_q;
   end

   // Eight MAC lanes; the first sample of a row loads rather than accumulates.
   always_comb begin
      for (int j = 0; j < 8; j++) begin
         cm[j]      = row_inv ? rom[cnt][j] : rom[j][cnt];
         prod[j]    = PROD_W'(a_in) * PROD_W'(cm[j]);
         acc_nxt[j] = ((cnt == 3'd0) ? ACC_W'(0) : acc[j]) + ACC_W'(prod[j]);
`ifdef DCT_SAT_EN
         rnd[j] = (acc[j] + RND_HALF) >>> (COEF_W - 1);
         if (rnd[j] > SAT_HI)      res[j] = OUT_W'(SAT_HI);
         else if (rnd[j] < SAT_LO) res[j] = OUT_W'(SAT_LO);
         else                      res[j] = OUT_W'(rnd[j]);
`else
         res[j] = OUT_W'((acc[j] + RND_HALF) >>> (COEF_W - 1));
`endif
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= FILL;
         cnt        <= '0;
         mode_q     <= 1'b0;
         bank_valid <= 1'b0;
         idx        <= '0;
         inv_out    <= 1'b0;
         for (int j = 0; j < 8; j++) begin
            acc[j]  <= '0;
            bank[j] <= '0;
         end
      end else begin
         if (accept) begin
            cnt <= cnt + 3'd1;
            for (int j = 0; j < 8; j++) acc[j] <= acc_nxt[j];
            if (cnt == 3'd0) mode_q <= inv_in;
         end
         if ((state == FILL) && accept && (cnt == 3'd7)) state <= FULL;
         else if (transfer)                               state <= FILL;
         if (transfer) begin
            for (int j = 0; j < 8; j++) bank[j] <= res[j];
            bank_valid <= 1'b1;
            idx        <= '0;
            inv_out    <= mode_q;
         end else if (take) begin
            idx <= idx + 3'd1;
            if (idx == 3'd7) bank_valid <= 1'b0;
         end
      end
   end

   assign ena_out = bank_valid;
   assign S_out   = bank[idx];

endmodule

// File: tb/tb_dct_1d_gen.sv
// Bench for dct_1d_gen: directed rows checked against a real-valued DCT basis model and a scoreboard.
`timescale 1ns/1ps
module tb_dct_1d_gen;

   localparam int unsigned IN_W   = 12;
   localparam int unsigned OUT_W  = 12;
   localparam int unsigned COEF_W = 12;
   localparam int unsigned IN9_W  = 8;
   localparam int unsigned OUT9_W = 9;
   localparam real PI = 3.14159265358979323846;
`ifdef DCT_SAT_EN
   localparam int SAT_EXP = 255;
`else
   localparam int SAT_EXP = -153;
`endif

   logic clk = 1'b0;
   logic rst;
   logic ena_in, rdy_out, inv_in, ena_out, rdy_in, inv_out;
   logic signed [IN_W-1:0]  a_in;
   logic signed [OUT_W-1:0] S_out;
   logic ena9_in, rdy9_out, inv9_in, ena9_out, inv9_out;
   logic signed [IN9_W-1:0]  a9_in;
   logic signed [OUT9_W-1:0] S9_out;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   dct_1d_gen #(.IN_W(IN_W), .OUT_W(OUT_W), .COEF_W(COEF_W)) dut (
      .clk(clk), .rst(rst), .ena_in(ena_in), .rdy_out(rdy_out), .a_in(a_in), .inv_in(inv_in),
      .ena_out(ena_out), .rdy_in(rdy_in), .S_out(S_out), .inv_out(inv_out));

   dct_1d_gen #(.OUT_W(OUT9_W)) dut9 (
      .clk(clk), .rst(rst), .ena_in(ena9_in), .rdy_out(rdy9_out), .a_in(a9_in), .inv_in(inv9_in),
      .ena_out(ena9_out), .rdy_in(1'b1), .S_out(S9_out), .inv_out(inv9_out));

   typedef struct {int v; bit inv;} exp_t;
   exp_t exp_q[$];
   exp_t e_mon;
   int   got_q[$];
   int   out_cyc[$];
   int   rdy_low = 0;
   int   cq [8][8];

   int dc100[8] = '{100, 100, 100, 100, 100, 100, 100, 100};
   int imp64[8] = '{64, 0, 0, 0, 0, 0, 0, 0};
   int rt[8]    = '{65, 84, 88, 74, 71, 84, 91, 86};
   int s127[8]  = '{127, 127, 127, 127, 127, 127, 127, 127};
   int ra[8]    = '{-50, 20, 300, -400, 7, 0, 123, -1};
   int rb[8]    = '{250, -250, 250, -250, 250, -250, 250, -250};
   int rc[8]    = '{-300, -100, 0, 100, 300, 450, -450, 17};

   task automatic check(input string name, input logic signed [63:0] got, input logic signed [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0d, expected %0d", name, got, exp);
      end
   endtask

   // Quantised basis straight from the cosine definition, round to nearest with 11 fractional bits.
   function automatic int qcoef(input int k, input int n);
      real c;
      real s;
      c = ((k == 0) ? 1.0 / $sqrt(2.0) : 1.0) / 2.0 * $cos(real'((2 * n + 1) * k) * PI / 16.0);
      s = c * 2048.0;
      return (s >= 0.0) ? $rtoi(s + 0.5) : -$rtoi(-s + 0.5);
   endfunction

   function automatic int fit(input longint v, input int ow);
`ifdef DCT_SAT_EN
      longint hi;
      hi = (longint'(1) << (ow - 1)) - 1;
      if (v > hi) return int'(hi);
      if (v < -hi - 1) return int'(-hi - 1);
      return int'(v);
`else
      longint m;
      m = v & ((longint'(1) << ow) - 1);
      if (m >= (longint'(1) << (ow - 1))) m = m - (longint'(1) << ow);
      return int'(m);
`endif
   endfunction

   function automatic void model_row(input int x[8], input bit inv, input int ow, output int y[8]);
      for (int o = 0; o < 8; o++) begin
         longint a;
         a = 0;
         for (int i = 0; i < 8; i++) a += longint'(x[i]) * longint'(inv ? cq[i][o] : cq[o][i]);
         y[o] = fit((a + 1024) >>> 11, ow);
      end
   endfunction

   // Scoreboard on every taken word, plus hold-stability while stalled.
   bit hold_v = 1'b0;
   logic signed [OUT_W-1:0] hold_s;
   logic hold_i;
   always @(negedge clk) begin
      if (rst) begin
         hold_v = 1'b0;
      end else begin
         if (ena_in && !rdy_out) rdy_low++;
         if (hold_v) begin
            check("hold_ena", ena_out, 1);
            check("hold_S", S_out, hold_s);
            check("hold_inv", inv_out, hold_i);
         end
         hold_v = 1'b0;
         if (ena_out && !rdy_in) begin
            hold_v = 1'b1;
            hold_s = S_out;
            hold_i = inv_out;
         end
         if (ena_out && rdy_in) begin
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_output: got %0d with nothing expected", S_out);
            end else begin
               e_mon = exp_q.pop_front();
               check("S_out", S_out, e_mon.v);
               check("inv_out", inv_out, e_mon.inv);
            end
            got_q.push_back(int'(S_out));
            out_cyc.push_back(cyc);
         end
      end
   end

   // Drives n samples; mode toggles after sample 0 so a mid-row inv_in change is exercised.
   task automatic send_row(input int x[8], input bit inv, input int gap, input int n);
      int y[8];
      int waited;
      bit ok;
      for (int i = 0; i < n; i++) begin
         if (gap > 0) begin
            ena_in = 1'b0;
            repeat (gap) @(posedge clk);
            #1;
         end
         ena_in = 1'b1;
         a_in   = IN_W'(x[i]);
         inv_in = (i == 0) ? inv : !inv;
         ok     = 1'b0;
         waited = 0;
         while (!ok) begin
            @(negedge clk);
            ok = rdy_out;
            @(posedge clk);
            #1;
            if (!ok) begin
               waited++;
               if (waited > 1000) begin
                  total++;
                  bad++;
                  $display("FAIL send_timeout: rdy_out low for %0d cycles, required high", waited);
                  ena_in = 1'b0;
                  return;
               end
            end
         end
      end
      ena_in = 1'b0;
      if (n == 8) begin
         model_row(x, inv, OUT_W, y);
         for (int k = 0; k < 8; k++) exp_q.push_back('{y[k], inv});
      end
   endtask

   task automatic drain();
      int w;
      w = 0;
      while (exp_q.size() != 0 && w < 2000) begin
         @(posedge clk);
         w++;
      end
      check("drain_left", exp_q.size(), 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("idle_ena", ena_out, 0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int y[8];
      int fwd[8];
      int base;
      int base2;
      int w;
      int d;
      for (int k = 0; k < 8; k++)
         for (int n = 0; n < 8; n++) cq[k][n] = qcoef(k, n);

      rst = 1'b1; ena_in = 1'b0; a_in = '0; inv_in = 1'b0; rdy_in = 1'b1;
      ena9_in = 1'b0; a9_in = '0; inv9_in = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_ena_out", ena_out, 0);
      check("rst_rdy_out", rdy_out, 1);
      check("rst_S_out", S_out, 0);
      check("rst_inv_out", inv_out, 0);
      @(posedge clk); #1;
      rst = 1'b0;

      model_row(dc100, 1'b0, OUT_W, y);
      check("model_dc_k0", y[0], 283);
      check("model_dc_k3", y[3], 0);
      model_row(imp64, 1'b1, OUT_W, y);
      check("model_imp_n0", y[0], 23);
      check("model_imp_n7", y[7], 23);
      model_row(rt, 1'b0, OUT_W, y);
      check("model_rt_k0", y[0], 227);
      model_row(s127, 1'b0, OUT9_W, y);
      check("model_sat", y[0], SAT_EXP);

      // DC row and first-output latency
      base = got_q.size();
      send_row(dc100, 1'b0, 0, 8);
      @(negedge clk);
      check("lat_before", ena_out, 0);
      @(negedge clk);
      check("lat_first", ena_out, 1);
      check("dc_first_literal", S_out, 283);
      @(posedge clk); #1;
      drain();
      check("dc_count", got_q.size() - base, 8);

      // Inverse impulse
      base = got_q.size();
      send_row(imp64, 1'b1, 0, 8);
      drain();
      check("imp_count", got_q.size() - base, 8);
      if (got_q.size() - base == 8) begin
         check("imp_first_literal", got_q[base], 23);
         check("imp_last_literal", got_q[base + 7], 23);
      end

      // Round trip, with input gaps
      base = got_q.size();
      send_row(rt, 1'b0, 1, 8);
      drain();
      check("rt_fwd_count", got_q.size() - base, 8);
      for (int k = 0; k < 8; k++) fwd[k] = (base + k < got_q.size()) ? got_q[base + k] : 0;
      check("rt_fwd_dc", fwd[0], 227);
      base2 = got_q.size();
      send_row(fwd, 1'b1, 2, 8);
      drain();
      check("rt_inv_count", got_q.size() - base2, 8);
      for (int n = 0; n < 8; n++) begin
         d = (base2 + n < got_q.size()) ? got_q[base2 + n] - rt[n] : 9999;
         check("rt_within_2", (d <= 2) && (d >= -2), 1);
      end

      // Three rows back to back, no stall
      rdy_low = 0;
      base = got_q.size();
      send_row(ra, 1'b0, 0, 8);
      send_row(rb, 1'b1, 0, 8);
      send_row(rc, 1'b0, 0, 8);
      drain();
      check("tp_count", got_q.size() - base, 24);
      if (got_q.size() - base == 24) check("tp_span", out_cyc[base + 23] - out_cyc[base], 23);
      check("tp_rdy_low", rdy_low, 0);

      // Same rows with a 20-cycle downstream stall after the first output
      rdy_low = 0;
      base = got_q.size();
      fork
         begin
            send_row(ra, 1'b1, 0, 8);
            send_row(rb, 1'b0, 0, 8);
            send_row(rc, 1'b1, 0, 8);
         end
         begin
            w = 0;
            while (!ena_out && w < 1000) begin
               @(negedge clk);
               w++;
            end
            @(posedge clk); #1;
            rdy_in = 1'b0;
            repeat (20) @(posedge clk);
            #1;
            rdy_in = 1'b1;
         end
      join
      drain();
      check("bp_count", got_q.size() - base, 24);
      check("bp_rdy_dropped", rdy_low > 0, 1);

      // OUT_W=9 overflow on the DC term
      @(negedge clk);
      check("sat_rdy", rdy9_out, 1);
      @(posedge clk); #1;
      ena9_in = 1'b1; a9_in = IN9_W'(127); inv9_in = 1'b0;
      repeat (8) @(posedge clk);
      #1;
      ena9_in = 1'b0;
      w = 0;
      @(negedge clk);
      while (!ena9_out && w < 100) begin
         @(negedge clk);
         w++;
      end
      model_row(s127, 1'b0, OUT9_W, y);
      check("sat_ena", ena9_out, 1);
      check("sat_S0_literal", S9_out, SAT_EXP);
      check("sat_S0_model", S9_out, y[0]);
      check("sat_inv", inv9_out, 0);
      @(negedge clk);
      check("sat_S1", S9_out, y[1]);
      @(posedge clk); #1;

      // Reset while a row is being emitted and another is half filled
      send_row(rc, 1'b1, 0, 8);
      send_row(rb, 1'b0, 0, 4);
      check("pre_rst_ena", ena_out, 1);
      check("pre_rst_inv", inv_out, 1);
      rst = 1'b1;
      #1;
      check("mid_rst_ena", ena_out, 0);
      check("mid_rst_rdy", rdy_out, 1);
      check("mid_rst_S", S_out, 0);
      check("mid_rst_inv", inv_out, 0);
      exp_q.delete();
      @(posedge clk); #1;
      rst = 1'b0;
      base = got_q.size();
      send_row(dc100, 1'b0, 0, 8);
      drain();
      check("post_rst_count", got_q.size() - base, 8);
      if (got_q.size() - base == 8) begin
         check("post_rst_dc", got_q[base], 283);
         check("post_rst_k1", got_q[base + 1], 0);
      end

      check("final_queue", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
